// File: rtl/hamster_ramp_pkg.sv
// Shared types and saturating ramp arithmetic for the motor ramp controller.
package hamster_ramp_pkg;

   localparam int unsigned DEF_NMOT   = 2;
   localparam int unsigned DEF_PWMRES = 8;
   localparam int unsigned DEF_TRES   = 16;
   localparam int unsigned RAMP_MAXW  = 16;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DECEL = 2'd1,
      DWELL = 2'd2,
      BRAKE = 2'd3
   } ramp_state_t;

   // min(a + b, lim); the extra carry bit keeps the sum from wrapping
   function automatic logic [RAMP_MAXW-1:0] ramp_sat_add(input logic [RAMP_MAXW-1:0] a,
                                                         input logic [RAMP_MAXW-1:0] b,
                                                         input logic [RAMP_MAXW-1:0] lim);
      logic [RAMP_MAXW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s > {1'b0, lim}) return lim;
      return s[RAMP_MAXW-1:0];
   endfunction

   // max(a - b, floor); a borrow means the result went below zero
   function automatic logic [RAMP_MAXW-1:0] ramp_sat_sub(input logic [RAMP_MAXW-1:0] a,
                                                         input logic [RAMP_MAXW-1:0] b,
                                                         input logic [RAMP_MAXW-1:0] floor);
      logic [RAMP_MAXW:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[RAMP_MAXW] || (d[RAMP_MAXW-1:0] < floor)) return floor;
      return d[RAMP_MAXW-1:0];
   endfunction

endpackage

// File: rtl/motor_ramp_chan.sv
// One motor channel: command latch, slew-limited PWM ramp and reversal sequencing.
module motor_ramp_chan
   import hamster_ramp_pkg::*;
#(
   parameter int unsigned K_PWMRES = DEF_PWMRES,
   parameter int unsigned K_TRES   = DEF_TRES
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_tick,
   input  logic                i_cmd_valid,
   input  logic [K_PWMRES-1:0] i_target,
   input  logic                i_reverse,
   input  logic                i_force_zero,
   input  logic                i_brake_req,
   input  logic [K_PWMRES-1:0] i_step,
   input  logic [K_TRES-1:0]   i_dwell,
   output logic [K_PWMRES-1:0] o_pwm_cmd,
   output logic                o_reverse,
   output logic                o_brake,
   output logic                o_settled_c
);

   ramp_state_t         state_q, state_d;
   logic [K_PWMRES-1:0] out_q, out_d;
   logic [K_PWMRES-1:0] tgt_q, tgt_d;
   logic                lrev_q, lrev_d;
   logic                rev_q, rev_d;
   logic                brake_q, brake_d;
   logic [K_TRES-1:0]   cnt_q, cnt_d;

   logic [K_PWMRES-1:0] up_c, down_c, decel_c;
   logic [K_TRES:0]     cnt_inc_c;

   assign up_c      = K_PWMRES'(ramp_sat_add(RAMP_MAXW'(out_q), RAMP_MAXW'(i_step), RAMP_MAXW'(tgt_q)));
   assign down_c    = K_PWMRES'(ramp_sat_sub(RAMP_MAXW'(out_q), RAMP_MAXW'(i_step), RAMP_MAXW'(tgt_q)));
   assign decel_c   = K_PWMRES'(ramp_sat_sub(RAMP_MAXW'(out_q), RAMP_MAXW'(i_step), RAMP_MAXW'(0)));
   assign cnt_inc_c = {1'b0, cnt_q} + (K_TRES+1)'(1);

   // Next-state: brake overrides everything; direction mismatch is checked every clock
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      tgt_d   = tgt_q;
      lrev_d  = lrev_q;
      rev_d   = rev_q;
      cnt_d   = cnt_q;

      if (i_force_zero)     tgt_d = '0;
      else if (i_cmd_valid) tgt_d = i_target;
      if (i_cmd_valid)      lrev_d = i_reverse;

      if (i_brake_req) begin
         state_d = BRAKE;
         out_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (lrev_q != rev_q) begin
                  state_d = (out_q != '0) ? DECEL : DWELL;
                  cnt_d   = '0;
               end else if (i_tick) begin
                  out_d = (out_q < tgt_q) ? up_c : down_c;
               end
            end
            DECEL: begin
               if (i_tick) begin
                  out_d = decel_c;
                  if (decel_c == '0) begin
                     state_d = DWELL;
                     cnt_d   = '0;
                  end
               end
            end
            DWELL: begin
               if (lrev_q == rev_q) begin
                  state_d = RUN;
               end else if (i_tick) begin
                  if ((i_dwell == '0) || (cnt_inc_c >= {1'b0, i_dwell})) begin
                     rev_d   = lrev_q;
                     state_d = RUN;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc_c[K_TRES-1:0];
                  end
               end
            end
            BRAKE: state_d = RUN;
            default: state_d = RUN;
         endcase
      end

      brake_d = (state_d == BRAKE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= RUN;
         out_q   <= '0;
         tgt_q   <= '0;
         lrev_q  <= 1'b0;
         rev_q   <= 1'b0;
         brake_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         tgt_q   <= tgt_d;
         lrev_q  <= lrev_d;
         rev_q   <= rev_d;
         brake_q <= brake_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_pwm_cmd   = out_q;
   assign o_reverse   = rev_q;
   assign o_brake     = brake_q;
   assign o_settled_c = (state_q == RUN) && (out_q == tgt_q);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Ramp controller for K_NMOT motors with a shared command watchdog and sticky fault.
module motor_ramp_ctrl
   import hamster_ramp_pkg::*;
#(
   parameter int unsigned K_NMOT   = DEF_NMOT,
   parameter int unsigned K_PWMRES = DEF_PWMRES,
   parameter int unsigned K_TRES   = DEF_TRES
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_tick,
   input  logic                       i_cmd_valid,
   input  logic [K_NMOT*K_PWMRES-1:0] i_target,
   input  logic [K_NMOT-1:0]          i_reverse,
   input  logic                       i_brake,
   input  logic [K_PWMRES-1:0]        i_step,
   input  logic [K_TRES-1:0]          i_dwell,
   input  logic [K_TRES-1:0]          i_wdg_thr,
   input  logic                       i_fault_clr,
   output logic [K_NMOT*K_PWMRES-1:0] o_pwm_cmd,
   output logic [K_NMOT-1:0]          o_reverse,
   output logic [K_NMOT-1:0]          o_brake,
   output logic [K_NMOT-1:0]          o_settled,
   output logic                       o_fault
);

   logic [K_TRES-1:0] wdg_cnt_q, wdg_cnt_d;
   logic              fault_q, fault_d;
   logic              timeout_c;
   logic              brake_req_c;

   assign timeout_c   = (i_wdg_thr != '0) && (wdg_cnt_q >= i_wdg_thr);
   assign brake_req_c = i_brake | fault_q;

   // Watchdog counts ticks since the last command; a timeout beats a same-cycle clear
   always_comb begin
      wdg_cnt_d = wdg_cnt_q;
      fault_d   = fault_q;
      if (i_cmd_valid)                       wdg_cnt_d = '0;
      else if (i_tick && (wdg_cnt_q != '1))  wdg_cnt_d = wdg_cnt_q + K_TRES'(1);
      if (timeout_c)        fault_d = 1'b1;
      else if (i_fault_clr) fault_d = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wdg_cnt_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         wdg_cnt_q <= wdg_cnt_d;
         fault_q   <= fault_d;
      end
   end

   assign o_fault = fault_q;

   for (genvar g = 0; g < int'(K_NMOT); g++) begin : g_chan
      motor_ramp_chan #(
         .K_PWMRES (K_PWMRES),
         .K_TRES   (K_TRES)
      ) u_chan (
         .i_clk        (i_clk),
         .i_rst_n      (i_rst_n),
         .i_tick       (i_tick),
         .i_cmd_valid  (i_cmd_valid),
         .i_target     (i_target[g*K_PWMRES +: K_PWMRES]),
         .i_reverse    (i_reverse[g]),
         .i_force_zero (timeout_c),
         .i_brake_req  (brake_req_c),
         .i_step       (i_step),
         .i_dwell      (i_dwell),
         .o_pwm_cmd    (o_pwm_cmd[g*K_PWMRES +: K_PWMRES]),
         .o_reverse    (o_reverse[g]),
         .o_brake      (o_brake[g]),
         .o_settled_c  (o_settled[g])
      );
   end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl: vector table, directed corner sequences, random vs model.
module tb_motor_ramp_ctrl;

   localparam int NM = 2;
   localparam int PW = 8;
   localparam int TW = 16;

   localparam int P_RUN  = 0;
   localparam int P_SLOW = 1;
   localparam int P_WAIT = 2;
   localparam int P_BRK  = 3;

   logic             clk;
   logic             rst_n;
   logic             tick;
   logic             cmd_valid;
   logic [NM*PW-1:0] target;
   logic [NM-1:0]    reverse;
   logic             brake;
   logic [PW-1:0]    step;
   logic [TW-1:0]    dwell;
   logic [TW-1:0]    wdg_thr;
   logic             fault_clr;
   logic [NM*PW-1:0] pwm_cmd;
   logic [NM-1:0]    rev_o;
   logic [NM-1:0]    brake_o;
   logic [NM-1:0]    settled;
   logic             fault;

   motor_ramp_ctrl dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_tick      (tick),
      .i_cmd_valid (cmd_valid),
      .i_target    (target),
      .i_reverse   (reverse),
      .i_brake     (brake),
      .i_step      (step),
      .i_dwell     (dwell),
      .i_wdg_thr   (wdg_thr),
      .i_fault_clr (fault_clr),
      .o_pwm_cmd   (pwm_cmd),
      .o_reverse   (rev_o),
      .o_brake     (brake_o),
      .o_settled   (settled),
      .o_fault     (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   // Reference model: per-motor speed, applied direction, requested direction, phase
   int m_out[NM];
   int m_dir[NM];
   int m_tgt[NM];
   int m_req[NM];
   int m_ph[NM];
   int m_wait[NM];
   int m_wcnt;
   int m_flt;

   task automatic model_reset();
      for (int c = 0; c < NM; c++) begin
         m_out[c] = 0; m_dir[c] = 0; m_tgt[c] = 0; m_req[c] = 0; m_ph[c] = P_RUN; m_wait[c] = 0;
      end
      m_wcnt = 0;
      m_flt  = 0;
   endtask

   task automatic model_update();
      int  stp, hold, thr;
      bit  expired, stop_all;
      stp      = int'(step);
      hold     = (dwell == '0) ? 1 : int'(dwell);
      thr      = int'(wdg_thr);
      expired  = (thr != 0) && (m_wcnt >= thr);
      stop_all = brake || (m_flt != 0);
      for (int c = 0; c < NM; c++) begin
         if (stop_all) begin
            m_ph[c] = P_BRK; m_out[c] = 0; m_wait[c] = 0;
         end else if (m_ph[c] == P_BRK) begin
            m_ph[c] = P_RUN;
         end else if (m_ph[c] == P_RUN) begin
            if (m_req[c] != m_dir[c]) begin
               m_ph[c]   = (m_out[c] != 0) ? P_SLOW : P_WAIT;
               m_wait[c] = 0;
            end else if (tick) begin
               if (m_out[c] < m_tgt[c]) m_out[c] = (m_out[c] + stp > m_tgt[c]) ? m_tgt[c] : m_out[c] + stp;
               else                     m_out[c] = (m_out[c] - stp < m_tgt[c]) ? m_tgt[c] : m_out[c] - stp;
            end
         end else if (m_ph[c] == P_SLOW) begin
            if (tick) begin
               m_out[c] = (m_out[c] > stp) ? m_out[c] - stp : 0;
               if (m_out[c] == 0) begin m_ph[c] = P_WAIT; m_wait[c] = 0; end
            end
         end else begin
            if (m_req[c] == m_dir[c]) m_ph[c] = P_RUN;
            else if (tick) begin
               m_wait[c]++;
               if (m_wait[c] >= hold) begin m_dir[c] = m_req[c]; m_ph[c] = P_RUN; m_wait[c] = 0; end
            end
         end
         if (expired)        m_tgt[c] = 0;
         else if (cmd_valid) m_tgt[c] = int'(target[c*PW +: PW]);
         if (cmd_valid)      m_req[c] = int'(reverse[c]);
      end
      if (cmd_valid) m_wcnt = 0;
      else if (tick && m_wcnt < 65535) m_wcnt++;
      if (expired)        m_flt = 1;
      else if (fault_clr) m_flt = 0;
   endtask

   function automatic logic [22:0] pack(input int p0, input int p1, input logic [1:0] rv,
                                        input logic [1:0] bk, input logic [1:0] st, input logic fl);
      return {8'(p1), 8'(p0), rv, bk, st, fl};
   endfunction

   function automatic logic [22:0] model_pack();
      logic [1:0] rv, bk, st;
      for (int c = 0; c < NM; c++) begin
         rv[c] = (m_dir[c] != 0);
         bk[c] = (m_ph[c] == P_BRK);
         st[c] = (m_ph[c] == P_RUN) && (m_out[c] == m_tgt[c]);
      end
      return pack(m_out[0], m_out[1], rv, bk, st, m_flt != 0);
   endfunction

   task automatic chk(input string nm, input logic [22:0] exp);
      logic [22:0] act;
      act = {pwm_cmd, rev_o, brake_o, settled, fault};
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got {pwm1,pwm0,rev,brk,set,flt}=%h expected %h", nm, act, exp);
      end
   endtask

   // One clock with the given strobes; returns 1 time unit after the edge
   task automatic go(input logic cv, input logic tk, input logic clr);
      cmd_valid = cv; tick = tk; fault_clr = clr;
      model_update();
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; tick = 1'b0; fault_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0; tick = 1'b0; fault_clr = 1'b0; brake = 1'b0;
      target = '0; reverse = '0; step = '0; dwell = 16'd3; wdg_thr = '0;
      #7;
      model_reset();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic       cv;
      logic       tk;
      logic [7:0] t0;
      logic [7:0] stp;
      int         e0;
      logic       es0;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mkv(input logic cv, input logic tk, input int t0, input int stp,
                                input int e0, input logic es0);
      vec_t v;
      v.cv = cv; v.tk = tk; v.t0 = 8'(t0); v.stp = 8'(stp); v.e0 = e0; v.es0 = es0;
      return v;
   endfunction

   initial begin
      int          thr_set[4];
      int          cv_div[4];
      int          ep0[12];
      int          ep1[12];
      logic [1:0]  es[12];
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      do_reset();
      chk("reset", pack(0, 0, 2'b00, 2'b00, 2'b11, 1'b0));

      // Ramp 0->200 by 16, then latency, saturation and step-0 corners on motor 0
      tbl.push_back(mkv(1, 0, 200, 16, 0, 0));
      for (int k = 1; k <= 13; k++) tbl.push_back(mkv(0, 1, 200, 16, (16*k > 200) ? 200 : 16*k, k == 13));
      tbl.push_back(mkv(1, 0, 0, 16, 200, 0));
      tbl.push_back(mkv(0, 1, 0, 255, 0, 1));
      tbl.push_back(mkv(1, 1, 100, 10, 0, 0));
      for (int k = 1; k <= 10; k++) tbl.push_back(mkv(0, 1, 100, 10, 10*k, k == 10));
      tbl.push_back(mkv(1, 0, 255, 10, 100, 0));
      tbl.push_back(mkv(0, 1, 255, 200, 255, 1));
      tbl.push_back(mkv(1, 1, 50, 0, 255, 0));
      tbl.push_back(mkv(0, 1, 50, 0, 255, 0));
      tbl.push_back(mkv(0, 1, 50, 0, 255, 0));
      tbl.push_back(mkv(0, 1, 50, 5, 250, 0));
      foreach (tbl[i]) begin
         target = {8'd0, tbl[i].t0};
         step   = tbl[i].stp;
         go(tbl[i].cv, tbl[i].tk, 1'b0);
         chk($sformatf("tbl%0d", i), pack(tbl[i].e0, 0, 2'b00, 2'b00, {1'b1, tbl[i].es0}, 1'b0));
      end

      // Reversal: decelerate 200->0, dwell 3 ticks, flip, ramp again
      do_reset();
      step = 8'd50; target = 16'd200;
      go(1, 0, 0);
      chk("rev_latch", pack(0, 0, 2'b00, 2'b00, 2'b10, 1'b0));
      for (int k = 1; k <= 4; k++) begin
         go(0, 1, 0);
         chk($sformatf("rev_up%0d", k), pack(50*k, 0, 2'b00, 2'b00, {1'b1, k == 4}, 1'b0));
      end
      reverse = 2'b01;
      go(1, 0, 0);
      chk("rev_req", pack(200, 0, 2'b00, 2'b00, 2'b11, 1'b0));
      go(0, 0, 0);
      chk("rev_decel", pack(200, 0, 2'b00, 2'b00, 2'b10, 1'b0));
      for (int k = 1; k <= 4; k++) begin
         go(0, 1, 0);
         chk($sformatf("rev_down%0d", k), pack(200 - 50*k, 0, 2'b00, 2'b00, 2'b10, 1'b0));
      end
      for (int k = 1; k <= 3; k++) begin
         go(0, 1, 0);
         chk($sformatf("rev_dwell%0d", k), pack(0, 0, (k == 3) ? 2'b01 : 2'b00, 2'b00, 2'b10, 1'b0));
      end
      go(0, 1, 0);
      chk("rev_reramp", pack(50, 0, 2'b01, 2'b00, 2'b10, 1'b0));

      // Direction request withdrawn during dwell: back to RUN without flipping
      do_reset();
      reverse = 2'b01;
      go(1, 0, 0);
      chk("wd_latch", pack(0, 0, 2'b00, 2'b00, 2'b11, 1'b0));
      go(0, 0, 0);
      chk("wd_dwell", pack(0, 0, 2'b00, 2'b00, 2'b10, 1'b0));
      go(0, 1, 0);
      reverse = 2'b00;
      go(1, 0, 0);
      chk("wd_back", pack(0, 0, 2'b00, 2'b00, 2'b10, 1'b0));
      go(0, 0, 0);
      chk("wd_run", pack(0, 0, 2'b00, 2'b00, 2'b11, 1'b0));
      for (int k = 1; k <= 4; k++) go(0, 1, 0);
      chk("wd_noflip", pack(0, 0, 2'b00, 2'b00, 2'b11, 1'b0));

      // External brake mid-ramp, then release and re-ramp from 0
      do_reset();
      step = 8'd40; target = 16'd200;
      go(1, 0, 0);
      for (int k = 1; k <= 3; k++) go(0, 1, 0);
      chk("brk_pre", pack(120, 0, 2'b00, 2'b00, 2'b10, 1'b0));
      brake = 1'b1;
      go(0, 0, 0);
      chk("brk_on", pack(0, 0, 2'b00, 2'b11, 2'b00, 1'b0));
      go(0, 1, 0);
      chk("brk_hold", pack(0, 0, 2'b00, 2'b11, 2'b00, 1'b0));
      brake = 1'b0;
      go(0, 0, 0);
      chk("brk_off", pack(0, 0, 2'b00, 2'b00, 2'b10, 1'b0));
      go(0, 1, 0);
      chk("brk_reramp", pack(40, 0, 2'b00, 2'b00, 2'b10, 1'b0));

      // Watchdog timeout after 5 silent ticks; sticky fault and clear handling
      do_reset();
      wdg_thr = 16'd5; step = 8'd20; target = {8'd60, 8'd100};
      go(1, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         go(0, 1, 0);
         chk($sformatf("wdg_ramp%0d", k),
             pack(20*k, (20*k > 60) ? 60 : 20*k, 2'b00, 2'b00, {k >= 3, k == 5}, 1'b0));
      end
      ep0 = '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      ep1 = '{60, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      es  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      go(0, 0, 0);
      chk("wdg_fault", pack(ep0[0], ep1[0], 2'b00, 2'b00, es[0], 1'b1));
      go(0, 0, 1);
      chk("wdg_clr_lost", pack(0, 0, 2'b00, 2'b11, 2'b00, 1'b1));
      target = '0;
      go(1, 0, 0);
      chk("wdg_cv_keep", pack(0, 0, 2'b00, 2'b11, 2'b00, 1'b1));
      go(0, 0, 0);
      chk("wdg_still", pack(0, 0, 2'b00, 2'b11, 2'b00, 1'b1));
      go(0, 0, 1);
      chk("wdg_clr", pack(0, 0, 2'b00, 2'b11, 2'b00, 1'b0));
      go(0, 0, 0);
      chk("wdg_run", pack(0, 0, 2'b00, 2'b00, es[5], 1'b0));

      // Random traffic against the reference model
      thr_set = '{0, 7, 12, 40};
      cv_div  = '{6, 30, 10, 40};
      for (int s = 0; s < 4; s++) begin
         do_reset();
         wdg_thr = 16'(thr_set[s]);
         for (int n = 0; n < 600; n++) begin
            target  = 16'($urandom);
            reverse = 2'($urandom);
            step    = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 80));
            dwell   = 16'($urandom_range(0, 4));
            brake   = ($urandom_range(0, 39) == 0);
            go($urandom_range(0, cv_div[s] - 1) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 11) == 0);
            chk($sformatf("rnd%0d_%0d", s, n), model_pack());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
